// File: rtl/mul_pipe_ex.sv
// Parametrised integer multiply unit for the execute cluster: LAT-stage pipeline producing a
// 2*W-bit product with optional accumulate, full-pipeline stall on backpressure and flush.
module mul_pipe_ex #(
    parameter int unsigned W      = 32,
    parameter int unsigned LAT    = 3,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned GPR_W  = 6,
    parameter int unsigned HILO_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                go,
    output logic                go_ready,
    input  logic [7:0]          opcode,
    input  logic [W-1:0]        src_A,
    input  logic [W-1:0]        src_B,
    input  logic [2*W-1:0]      src_hilo,
    input  logic [ROB_W-1:0]    rob_ptr_in,
    input  logic [GPR_W-1:0]    gpr_prf_ptr_in,
    input  logic [HILO_W-1:0]   hilo_prf_ptr_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W-1:0]      y,
    output logic [ROB_W-1:0]    rob_ptr_out,
    output logic                gpr_prf_ptr_val_out,
    output logic [GPR_W-1:0]    gpr_prf_ptr_out,
    output logic                hilo_prf_ptr_val_out,
    output logic [HILO_W-1:0]   hilo_prf_ptr_out,
    output logic                busy
);

    localparam int unsigned YW = 2 * W;

    typedef enum logic [1:0] {AccNone, AccAdd, AccSub} acc_e;

    logic [LAT-1:0]    vld_q;
    logic [LAT-1:0]    gpr_q;
    logic [YW-1:0]     prod_q [LAT];
    logic [YW-1:0]     acc_q  [LAT];
    acc_e              mode_q [LAT];
    logic [ROB_W-1:0]  rob_q  [LAT];
    logic [GPR_W-1:0]  gptr_q [LAT];
    logic [HILO_W-1:0] hptr_q [LAT];

    logic          advance;
    logic          is_signed;
    logic          is_gpr;
    acc_e          mode_d;
    logic [YW-1:0] a_ext;
    logic [YW-1:0] b_ext;
    logic [YW-1:0] prod_d;

    // Opcode decode; anything unrecognised behaves as signed MULT.
    always_comb begin
        is_signed = 1'b1;
        mode_d    = AccNone;
        case (opcode)
            8'd12: is_signed = 1'b0;
            8'd66: mode_d = AccAdd;
            8'd67: begin
                is_signed = 1'b0;
                mode_d    = AccAdd;
            end
            8'd69: mode_d = AccSub;
            8'd70: begin
                is_signed = 1'b0;
                mode_d    = AccSub;
            end
            default: ;
        endcase
    end

    assign is_gpr = (opcode == 8'd68);
    assign a_ext  = is_signed ? {{W{src_A[W-1]}}, src_A} : {{W{1'b0}}, src_A};
    assign b_ext  = is_signed ? {{W{src_B[W-1]}}, src_B} : {{W{1'b0}}, src_B};
    assign prod_d = a_ext * b_ext;

    // Whole pipeline stalls when the last stage is held; no bubble compression.
    assign advance = !vld_q[LAT-1] || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            gpr_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
                mode_q[i] <= AccNone;
                rob_q[i]  <= '0;
                gptr_q[i] <= '0;
                hptr_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q <= {vld_q[LAT-2:0], go};
            end
            // Payload moves with advance regardless of flush; validity alone decides liveness.
            if (advance) begin
                gpr_q     <= {gpr_q[LAT-2:0], is_gpr};
                prod_q[0] <= prod_d;
                acc_q[0]  <= src_hilo;
                mode_q[0] <= mode_d;
                rob_q[0]  <= rob_ptr_in;
                gptr_q[0] <= gpr_prf_ptr_in;
                hptr_q[0] <= hilo_prf_ptr_in;
                for (int unsigned i = 1; i < LAT; i++) begin
                    prod_q[i] <= prod_q[i-1];
                    acc_q[i]  <= acc_q[i-1];
                    mode_q[i] <= mode_q[i-1];
                    rob_q[i]  <= rob_q[i-1];
                    gptr_q[i] <= gptr_q[i-1];
                    hptr_q[i] <= hptr_q[i-1];
                end
            end
        end
    end

    // Accumulate is applied combinationally on the last stage.
    always_comb begin
        y = prod_q[LAT-1];
        case (mode_q[LAT-1])
            AccAdd:  y = prod_q[LAT-1] + acc_q[LAT-1];
            AccSub:  y = prod_q[LAT-1] - acc_q[LAT-1];
            default: ;
        endcase
    end

    assign go_ready             = advance;
    assign out_valid            = vld_q[LAT-1];
    assign rob_ptr_out          = rob_q[LAT-1];
    assign gpr_prf_ptr_out      = gptr_q[LAT-1];
    assign hilo_prf_ptr_out     = hptr_q[LAT-1];
    assign gpr_prf_ptr_val_out  = vld_q[LAT-1] && gpr_q[LAT-1];
    assign hilo_prf_ptr_val_out = vld_q[LAT-1] && !gpr_q[LAT-1];
    assign busy                 = |vld_q;

endmodule

// File: tb/tb_mul_pipe_ex.sv
// Self-checking bench for mul_pipe_ex: directed cases from the block's rules plus randomized
// traffic scored against an in-order queue of arithmetic expectations.
module tb_mul_pipe_ex;

    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        reset, flush, go, out_ready;
    logic [7:0]  opcode;
    logic [31:0] src_A, src_B;
    logic [63:0] src_hilo;
    logic [4:0]  rob_ptr_in;
    logic [5:0]  gpr_prf_ptr_in;
    logic [1:0]  hilo_prf_ptr_in;

    logic        go_ready, out_valid, gpr_val, hilo_val, busy;
    logic [63:0] y;
    logic [4:0]  rob_out;
    logic [5:0]  gptr_out;
    logic [1:0]  hptr_out;

    logic        go2, go5;
    logic        gr2, ov2, gv2, hv2, busy2, gr5, ov5, gv5, hv5, busy5;
    logic [63:0] y2, y5;
    logic [4:0]  rob2, rob5;
    logic [5:0]  gp2, gp5;
    logic [1:0]  hp2, hp5;

    always #5 clk = ~clk;

    mul_pipe_ex #(.W(W), .LAT(3)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .go(go), .go_ready(go_ready),
        .opcode(opcode), .src_A(src_A), .src_B(src_B), .src_hilo(src_hilo),
        .rob_ptr_in(rob_ptr_in), .gpr_prf_ptr_in(gpr_prf_ptr_in),
        .hilo_prf_ptr_in(hilo_prf_ptr_in), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .rob_ptr_out(rob_out), .gpr_prf_ptr_val_out(gpr_val),
        .gpr_prf_ptr_out(gptr_out), .hilo_prf_ptr_val_out(hilo_val),
        .hilo_prf_ptr_out(hptr_out), .busy(busy)
    );

    mul_pipe_ex #(.W(W), .LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush), .go(go2), .go_ready(gr2),
        .opcode(opcode), .src_A(src_A), .src_B(src_B), .src_hilo(src_hilo),
        .rob_ptr_in(rob_ptr_in), .gpr_prf_ptr_in(gpr_prf_ptr_in),
        .hilo_prf_ptr_in(hilo_prf_ptr_in), .out_valid(ov2), .out_ready(1'b1),
        .y(y2), .rob_ptr_out(rob2), .gpr_prf_ptr_val_out(gv2), .gpr_prf_ptr_out(gp2),
        .hilo_prf_ptr_val_out(hv2), .hilo_prf_ptr_out(hp2), .busy(busy2)
    );

    mul_pipe_ex #(.W(W), .LAT(5)) u_dut5 (
        .clk(clk), .reset(reset), .flush(flush), .go(go5), .go_ready(gr5),
        .opcode(opcode), .src_A(src_A), .src_B(src_B), .src_hilo(src_hilo),
        .rob_ptr_in(rob_ptr_in), .gpr_prf_ptr_in(gpr_prf_ptr_in),
        .hilo_prf_ptr_in(hilo_prf_ptr_in), .out_valid(ov5), .out_ready(1'b1),
        .y(y5), .rob_ptr_out(rob5), .gpr_prf_ptr_val_out(gv5), .gpr_prf_ptr_out(gp5),
        .hilo_prf_ptr_val_out(hv5), .hilo_prf_ptr_out(hp5), .busy(busy5)
    );

    typedef struct {
        logic [63:0] y;
        logic [4:0]  rob;
        logic        gpr;
        logic [5:0]  gptr;
        logic [1:0]  hptr;
        int          t;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  delivered[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          last_lat = 0;
    logic [63:0] exp_y;
    logic [7:0]  ops [7] = '{8'd12, 8'd66, 8'd67, 8'd68, 8'd69, 8'd70, 8'd1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the opcode table.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        longint      sp;
        logic [63:0] s, u;
        sp = longint'($signed(a)) * longint'($signed(b));
        s  = 64'(sp);
        u  = {32'b0, a} * {32'b0, b};
        case (op)
            8'd12:   return u;
            8'd66:   return s + h;
            8'd67:   return u + h;
            8'd69:   return s - h;
            8'd70:   return u - h;
            default: return s;
        endcase
    endfunction

    // One clock cycle: score the outputs at the negedge, then record what was issued.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (go) chk("go_proto", 64'(go_ready), 64'(1));
        if (!out_valid) begin
            chk("gpr_val_idle", 64'(gpr_val), 64'(0));
            chk("hilo_val_idle", 64'(hilo_val), 64'(0));
        end else begin
            chk("spurious_out", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb[0];
                chk("y", y, e.y);
                chk("rob", 64'(rob_out), 64'(e.rob));
                chk("gpr_val", 64'(gpr_val), 64'(e.gpr));
                chk("hilo_val", 64'(hilo_val), 64'(!e.gpr));
                if (e.gpr) chk("gpr_ptr", 64'(gptr_out), 64'(e.gptr));
                else chk("hilo_ptr", 64'(hptr_out), 64'(e.hptr));
                if (out_ready && !reset) begin
                    last_lat = cyc_n - e.t;
                    delivered.push_back(e.rob);
                    void'(sb.pop_front());
                end
            end
        end
        if (reset || flush) begin
            sb.delete();
        end else if (go && go_ready) begin
            e.y = exp_y;
            e.rob = rob_ptr_in;
            e.gpr = (opcode == 8'd68);
            e.gptr = gpr_prf_ptr_in;
            e.hptr = hilo_prf_ptr_in;
            e.t = cyc_n;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic setup(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input logic [4:0] rob, input logic [63:0] ey);
        go = 1'b1;
        opcode = op;
        src_A = a;
        src_B = b;
        src_hilo = h;
        rob_ptr_in = rob;
        gpr_prf_ptr_in = 6'($urandom);
        hilo_prf_ptr_in = 2'($urandom);
        exp_y = ey;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input logic [4:0] rob, input logic [63:0] ey);
        setup(op, a, b, h, rob, ey);
        cyc();
        go = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_y"}, y, 64'(0));
        chk({tag, "_rob"}, 64'(rob_out), 64'(0));
        chk({tag, "_gptr"}, 64'(gptr_out), 64'(0));
        chk({tag, "_hptr"}, 64'(hptr_out), 64'(0));
        chk({tag, "_gval"}, 64'(gpr_val), 64'(0));
        chk({tag, "_hval"}, 64'(hilo_val), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_go_ready"}, 64'(go_ready), 64'(1));
    endtask

    // Single op into the LAT=2 (which=0) or LAT=5 (which=1) instance; count cycles to out_valid.
    task automatic lat_test(input int which, input int lat);
        int          n;
        logic [31:0] a, b;
        logic [63:0] h;
        a = $urandom;
        b = $urandom;
        h = {$urandom, $urandom};
        opcode = 8'd66;
        src_A = a;
        src_B = b;
        src_hilo = h;
        if (which == 0) go2 = 1'b1;
        else go5 = 1'b1;
        @(posedge clk);
        #1;
        go2 = 1'b0;
        go5 = 1'b0;
        n = 1;
        @(negedge clk);
        while (!(which == 0 ? ov2 : ov5) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(which == 0 ? "lat2_latency" : "lat5_latency", 64'(n), 64'(lat));
        chk(which == 0 ? "lat2_y" : "lat5_y", which == 0 ? y2 : y5, model(8'd66, a, b, h));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        go = 1'b0;
        go2 = 1'b0;
        go5 = 1'b0;
        out_ready = 1'b1;
        opcode = '0;
        src_A = '0;
        src_B = '0;
        src_hilo = '0;
        rob_ptr_in = '0;
        gpr_prf_ptr_in = '0;
        hilo_prf_ptr_in = '0;
        exp_y = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("reset");

        // Directed arithmetic cases.
        issue(8'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 5'd20, 64'hFFFF_FFFE_0000_0001);
        drain();
        chk("multu_latency", 64'(last_lat), 64'(3));
        issue(8'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 5'd21, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(8'd68, 32'd7, 32'd6, 64'd0, 5'd22, 64'd42);
        issue(8'd66, 32'd2, 32'd3, 64'd10, 5'd23, 64'd16);
        issue(8'd69, 32'd2, 32'd3, 64'd10, 5'd24, 64'hFFFF_FFFF_FFFF_FFFC);
        issue(8'd67, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd25,
              64'h0000_0000_FFFF_FFFE);
        drain();

        // Back-to-back with a 2-cycle stall at the first result.
        delivered.delete();
        issue(8'd12, 32'd11, 32'd13, 64'd0, 5'd1, 64'd143);
        issue(8'd68, 32'd5, 32'd9, 64'd0, 5'd2, 64'd45);
        issue(8'd66, 32'd4, 32'd4, 64'd1, 5'd3, 64'd17);
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_go_ready", 64'(go_ready), 64'(0));
            cyc();
        end
        out_ready = 1'b1;
        drain();
        chk("order_count", 64'(delivered.size()), 64'(3));
        if (delivered.size() == 3) begin
            chk("order_0", 64'(delivered[0]), 64'(1));
            chk("order_1", 64'(delivered[1]), 64'(2));
            chk("order_2", 64'(delivered[2]), 64'(3));
        end

        // Flush kills 4, 5 and the same-cycle go of 6.
        issue(8'd12, 32'd3, 32'd3, 64'd0, 5'd4, 64'd9);
        issue(8'd12, 32'd4, 32'd4, 64'd0, 5'd5, 64'd16);
        setup(8'd12, 32'd5, 32'd5, 64'd0, 5'd6, 64'd25);
        flush = 1'b1;
        cyc();
        go = 1'b0;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        repeat (6) cyc();
        delivered.delete();
        issue(8'd68, 32'd8, 32'd8, 64'd0, 5'd7, 64'd64);
        drain();
        chk("post_flush_rob", 64'(delivered.size() == 1 ? delivered[0] : 5'd0), 64'(7));

        // Reset with three ops held in the pipe.
        issue(8'd12, 32'd1, 32'd1, 64'd0, 5'd8, 64'd1);
        issue(8'd12, 32'd2, 32'd2, 64'd0, 5'd9, 64'd4);
        issue(8'd12, 32'd3, 32'd3, 64'd0, 5'd10, 64'd9);
        out_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        check_zero("midreset");
        repeat (6) cyc();

        // Randomized traffic with random backpressure and occasional flush.
        for (int k = 0; k < 80; k++) begin
            logic [7:0]  op;
            logic [31:0] a, b;
            logic [63:0] h;
            int          idx;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            #1;
            if (go_ready && $urandom_range(0, 3) != 0) begin
                idx = $urandom_range(0, 6);
                op = (idx == 6) ? 8'($urandom) : ops[idx];
                a = $urandom;
                b = $urandom;
                h = {$urandom, $urandom};
                setup(op, a, b, h, 5'(k), model(op, a, b, h));
            end
            cyc();
            go = 1'b0;
            flush = 1'b0;
        end
        out_ready = 1'b1;
        drain();

        lat_test(0, 2);
        lat_test(1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_pipe_ex.md
Name: mul_pipe_ex

Overview:
- Parametrised successor to the fixed 3-stage integer multiply unit, placed in the execute cluster between the multiply/HILO issue queue and the completion/writeback bus.
- Generalised in operand width and pipeline depth.
- Adds unsigned madd/msub, output backpressure (out_ready), a pipeline flush for branch-mispredict/exception recovery, and a busy indication.
- Produces a 2*W-bit result (HI:LO, or LO only for GPR-writing MUL) together with ROB/PRF tags.

Parameters:
- W, 32, operand width; result width is 2*W.
- LAT, 3, pipeline depth in cycles from go to out_valid; legal range 2..8.
- ROB_W, 5, ROB pointer width.
- GPR_W, 6, GPR physical register pointer width.
- HILO_W, 2, HILO physical register pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- flush  in  1  kill every in-flight operation.
- go  in  1  issue one operation this cycle.
- go_ready  out  1  pipeline accepts go this cycle.
- opcode  in  8  operation select.
- src_A  in  W  multiplicand.
- src_B  in  W  multiplier.
- src_hilo  in  2*W  accumulator for madd/msub.
- rob_ptr_in  in  ROB_W  ROB tag.
- gpr_prf_ptr_in  in  GPR_W  destination GPR.
- hilo_prf_ptr_in  in  HILO_W  destination HILO.
- out_valid  out  1  result valid in the last stage.
- out_ready  in  1  writeback accepts the result.
- y  out  2*W  result.
- rob_ptr_out  out  ROB_W  tag of the result.
- gpr_prf_ptr_val_out  out  1  result writes a GPR.
- gpr_prf_ptr_out  out  GPR_W  GPR destination.
- hilo_prf_ptr_val_out  out  1  result writes HILO.
- hilo_prf_ptr_out  out  HILO_W  HILO destination.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset: every stage valid bit, tag, data and flag clears to 0. Consequently:
  - out_valid=0, y=0, all pointers 0, both *_val_out=0, busy=0.
  - go_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight work with no completion.
- Opcodes:
  - 12: MULTU, unsigned, HILO.
  - 66: MADD, signed, plus src_hilo.
  - 67: MADDU, unsigned, plus src_hilo.
  - 68: MUL, signed, GPR.
  - 69: MSUB, signed, minus src_hilo.
  - 70: MSUBU, unsigned, minus src_hilo.
  - Any other value: MULT, signed, HILO.
- Product:
  - Signed ops sign-extend both operands to 2*W; unsigned ops zero-extend.
  - The product is computed in stage 0.
  - The accumulate is applied combinationally on the last stage: y = prod + acc for madd, y = prod - acc for msub.
  - All arithmetic is modulo 2^(2*W); wrap-around is silent.
- Destination flags:
  - gpr_val = (opcode==68).
  - hilo_val = !gpr_val.
  - Both are qualified by valid.
- Pipeline:
  - LAT stages, each holding a valid bit plus payload.
  - advance = !out_valid || out_ready.
  - When advance=1, every stage shifts one position, and stage 0 captures go (valid=go).
  - When advance=0, all stages hold; the pipeline is fully stalled, with no bubble compression.
  - go_ready = advance.
  - go while go_ready=0 is an upstream protocol violation; the bench asserts it never happens.
  - Latency: an op accepted at cycle t presents out_valid at cycle t+LAT, assuming out_ready held at 1.
  - Throughput is 1 op/cycle when unstalled.
- Output hold: while out_valid=1 and out_ready=0, y and every tag output stay stable.
- Flush:
  - Next edge, all valid bits clear.
  - A go in the same cycle is discarded.
  - Flush has priority over advance and stall.
  - A result presented with out_valid=1 in the flush cycle counts as delivered only if out_ready=1 in that cycle.
- Invalid stage outputs:
  - When out_valid=0, gpr_prf_ptr_val_out=0 and hilo_prf_ptr_val_out=0.
  - y and the pointers are don't-care.
- busy = OR of all stage valid bits.

Test Plan:
- W=32, LAT=3: MULTU 0xFFFFFFFF*0xFFFFFFFF at t → y=0xFFFFFFFE00000001 at t+3, hilo_val=1, gpr_val=0.
- MULT signed -2*3 → y=0xFFFFFFFFFFFFFFFA. MUL (68) 7*6 → y=42, gpr_val=1, gpr_prf_ptr_out equals the issued pointer.
- MADD 2*3 with src_hilo=10 → 16. MSUB 2*3 with src_hilo=10 → 0xFFFFFFFFFFFFFFFC. MADDU 0xFFFFFFFF*1 with src_hilo=0xFFFFFFFFFFFFFFFF → 0x00000000FFFFFFFE (wrap).
- Back-to-back issue of rob 1,2,3 with out_ready low for 2 cycles at the first result:
  - go_ready=0 during the stall.
  - y/rob stay stable.
  - Results emerge in order 1,2,3 with no loss or duplication.
- Issue rob 4,5, then flush together with go(rob 6) one cycle later:
  - No out_valid for 4, 5 or 6.
  - busy=0 the cycle after the flush.
  - A new op completes normally.
- Assert reset with 3 ops in flight:
  - All outputs 0 next cycle and none complete.
  - Repeat the latency check with LAT=2 and LAT=5.
